// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: round sequencer for the game.
// Walks IDLE -> COUNTDOWN -> PLAYING <-> INVULN -> GAME_OVER -> IDLE.
// It keeps lives and a tick-based score, and it owns game_active, which
// enables the collision block.
//
// Interface with the collision block:
//   game_active is high only while in PLAYING.
//   is_collision is a sticky flag. It is cleared only while game_active is low.
//   Every hit therefore passes through INVULN (or GAME_OVER). That holds
//   game_active low for at least one cycle before PLAYING is entered again.
//
// The state output is the registered FSM state. It doubles as the debug view.
module game_flow_ctrl #(
    parameter int TICK_DIV        = 10_000_000,
    parameter int COUNTDOWN_TICKS = 30,
    parameter int INVULN_TICKS    = 20,
    parameter int START_LIVES     = 3
) (
    input  logic        clock_100mhz,
    input  logic        reset_n,
    input  logic        start_btn,
    input  logic        is_collision,
    output logic        game_active,
    output logic [2:0]  state,
    output logic [1:0]  lives,
    output logic [13:0] score,
    output logic [5:0]  countdown,
    output logic        invuln,
    output logic        game_over
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST    = TW'(TICK_DIV - 1);
    localparam logic [13:0]   SCORE_MAX    = 14'd9999;
    localparam logic [5:0]    CD_LOAD      = 6'(COUNTDOWN_TICKS);
    localparam logic [7:0]    INV_LOAD     = 8'(INVULN_TICKS);
    localparam logic [1:0]    LIVES_LOAD   = 2'(START_LIVES);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAYING   = 3'd2,
        ST_INVULN    = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          start_prev;
    logic          start_edge;
    logic [7:0]    inv_timer;
    logic [7:0]    inv_timer_d;
    logic [1:0]    lives_d;
    logic [13:0]   score_d;
    logic [13:0]   score_sat_inc;
    logic [5:0]    countdown_d;

    assign tick          = (tick_cnt == TICK_LAST);
    assign start_edge    = start_btn & ~start_prev;
    assign score_sat_inc = (score == SCORE_MAX) ? score : score + 14'd1;
    assign state         = state_q;

    // Remember the previous start level. It resets high, so a button held
    // through reset release does not count as a press.
    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            start_prev <= 1'b1;
        end else begin
            start_prev <= start_btn;
        end
    end

    // Tick divider. It restarts on every state change, so the first tick in
    // a state arrives a full TICK_DIV cycles after entry.
    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (state_d != state_q) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Next-state and datapath updates for the round flow.
    always_comb begin
        state_d     = state_q;
        lives_d     = lives;
        score_d     = score;
        countdown_d = countdown;
        inv_timer_d = inv_timer;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    lives_d     = LIVES_LOAD;
                    score_d     = '0;
                    countdown_d = CD_LOAD;
                    state_d     = ST_COUNTDOWN;
                end
            end
            ST_COUNTDOWN: begin
                if (tick) begin
                    if (countdown == 6'd1) begin
                        countdown_d = '0;
                        state_d     = ST_PLAYING;
                    end else begin
                        countdown_d = countdown - 6'd1;
                    end
                end
            end
            ST_PLAYING: begin
                // A hit wins over a coincident tick. The score does not
                // advance in that cycle.
                if (is_collision) begin
                    if (lives == 2'd1) begin
                        lives_d = 2'd0;
                        state_d = ST_GAME_OVER;
                    end else begin
                        lives_d     = lives - 2'd1;
                        inv_timer_d = INV_LOAD;
                        state_d     = ST_INVULN;
                    end
                end else if (tick) begin
                    score_d = score_sat_inc;
                end
            end
            ST_INVULN: begin
                if (tick) begin
                    score_d = score_sat_inc;
                    if (inv_timer == 8'd1) begin
                        inv_timer_d = '0;
                        state_d     = ST_PLAYING;
                    end else begin
                        inv_timer_d = inv_timer - 8'd1;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (start_edge) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers. The flags are decoded from the next state,
    // so they change on the same edge as state.
    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            lives       <= LIVES_LOAD;
            score       <= '0;
            countdown   <= '0;
            inv_timer   <= '0;
            game_active <= 1'b0;
            invuln      <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives       <= lives_d;
            score       <= score_d;
            countdown   <= countdown_d;
            inv_timer   <= inv_timer_d;
            game_active <= (state_d == ST_PLAYING);
            invuln      <= (state_d == ST_INVULN);
            game_over   <= (state_d == ST_GAME_OVER);
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl. It runs directed round scenarios, then random
// button and collision traffic. All outputs are compared every cycle against
// a rule-level model of the round flow.
module tb_game_flow_ctrl;

    localparam int TICK_DIV        = 4;
    localparam int COUNTDOWN_TICKS = 3;
    localparam int INVULN_TICKS    = 2;
    localparam int START_LIVES     = 3;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_btn;
    logic        is_collision;
    logic        game_active;
    logic [2:0]  state;
    logic [1:0]  lives;
    logic [13:0] score;
    logic [5:0]  countdown;
    logic        invuln;
    logic        game_over;

    always #5 clk = ~clk;

    game_flow_ctrl #(
        .TICK_DIV(TICK_DIV),
        .COUNTDOWN_TICKS(COUNTDOWN_TICKS),
        .INVULN_TICKS(INVULN_TICKS),
        .START_LIVES(START_LIVES)
    ) dut (
        .clock_100mhz(clk),
        .reset_n(reset_n),
        .start_btn(start_btn),
        .is_collision(is_collision),
        .game_active(game_active),
        .state(state),
        .lives(lives),
        .score(score),
        .countdown(countdown),
        .invuln(invuln),
        .game_over(game_over)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // States: 0 idle, 1 countdown, 2 playing, 3 invulnerable, 4 game over.
    // m_age counts the cycles spent in the current state. A tick falls on
    // every TICK_DIV-th cycle of residence.
    int m_state, m_lives, m_score, m_cd, m_inv, m_age;
    bit m_prev;

    task automatic model_reset();
        m_state = 0; m_lives = START_LIVES; m_score = 0;
        m_cd = 0; m_inv = 0; m_age = 0; m_prev = 1'b1;
    endtask

    task automatic model_step(input bit b, input bit c);
        int ns;
        bit tk, edge_s;
        tk     = (m_age % TICK_DIV) == (TICK_DIV - 1);
        edge_s = b && !m_prev;
        m_prev = b;
        ns     = m_state;
        case (m_state)
            0: if (edge_s) begin
                   m_lives = START_LIVES; m_score = 0; m_cd = COUNTDOWN_TICKS; ns = 1;
               end
            1: if (tk) begin
                   m_cd = m_cd - 1;
                   if (m_cd == 0) ns = 2;
               end
            2: if (c) begin
                   m_lives = m_lives - 1;
                   if (m_lives == 0) ns = 4;
                   else begin m_inv = INVULN_TICKS; ns = 3; end
               end else if (tk) begin
                   m_score = (m_score + 1 > 9999) ? 9999 : m_score + 1;
               end
            3: if (tk) begin
                   m_score = (m_score + 1 > 9999) ? 9999 : m_score + 1;
                   m_inv = m_inv - 1;
                   if (m_inv == 0) ns = 2;
               end
            4: if (edge_s) ns = 0;
            default: ns = 0;
        endcase
        m_age   = (ns != m_state) ? 0 : m_age + 1;
        m_state = ns;
    endtask

    task automatic compare_all();
        check("state",       int'(state),       m_state);
        check("lives",       int'(lives),       m_lives);
        check("score",       int'(score),       m_score);
        check("countdown",   int'(countdown),   m_cd);
        check("game_active", int'(game_active), int'(m_state == 2));
        check("invuln",      int'(invuln),      int'(m_state == 3));
        check("game_over",   int'(game_over),   int'(m_state == 4));
    endtask

    // ---------------- driver tasks ----------------
    // One clock: drive inputs, advance the model on the edge, sample 1 later.
    task automatic cycle(input logic b, input logic c);
        start_btn    = b;
        is_collision = c;
        @(posedge clk);
        model_step(b, c);
        #1;
        compare_all();
    endtask

    // Asserts reset off-edge and checks the asynchronous effect before any clock.
    task automatic do_reset(input logic b);
        start_btn    = b;
        is_collision = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic wait_state(input int target, input int budget, output int n);
        n = 0;
        while (int'(state) != target && n < budget) begin
            cycle(1'b0, 1'b0);
            n++;
        end
    endtask

    task automatic align_to_tick();
        int guard = 0;
        while ((m_age % TICK_DIV) != (TICK_DIV - 1) && guard < TICK_DIV) begin
            cycle(1'b0, 1'b0);
            guard++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int s0;
        reset_n      = 1'b1;
        start_btn    = 1'b0;
        is_collision = 1'b0;

        do_reset(1'b0);
        check("rst_state", int'(state), 0);
        check("rst_lives", int'(lives), START_LIVES);
        repeat (3) cycle(1'b0, 1'b0);

        // The start press enters COUNTDOWN. PLAYING follows 12 cycles later.
        cycle(1'b1, 1'b0);
        check("cd_entry", int'(countdown), COUNTDOWN_TICKS);
        wait_state(2, 40, n);
        check("cd_dwell", n, COUNTDOWN_TICKS * TICK_DIV);
        check("play_active", int'(game_active), 1);

        // Five ticks of clean play.
        repeat (5 * TICK_DIV) cycle(1'b0, 1'b0);
        check("score_5", int'(score), 5);

        // A hit coincident with a tick leaves the score unchanged, then INVULN
        // adds two ticks.
        align_to_tick();
        s0 = m_score;
        cycle(1'b0, 1'b1);
        check("hit1_lives", int'(lives), 2);
        check("hit1_score", int'(score), s0);
        repeat (INVULN_TICKS * TICK_DIV) begin
            check("inv_active_low", int'(game_active), 0);
            cycle(1'b0, 1'b0);
        end
        check("inv_exit", int'(state), 2);
        check("inv_score", int'(score), s0 + INVULN_TICKS);

        // Two more hits end the round.
        cycle(1'b0, 1'b1);
        check("hit2_lives", int'(lives), 1);
        repeat (INVULN_TICKS * TICK_DIV + 3) cycle(1'b0, 1'b0);
        s0 = m_score;
        cycle(1'b0, 1'b1);
        check("hit3_over", int'(game_over), 1);
        check("hit3_lives", int'(lives), 0);
        repeat (20) cycle(1'b0, 1'b0);
        check("over_score_frozen", int'(score), s0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check("over_to_idle", int'(state), 0);
        cycle(1'b1, 1'b0);
        check("restart_lives", int'(lives), START_LIVES);
        check("restart_score", int'(score), 0);

        // Start presses during COUNTDOWN and PLAYING have no effect.
        repeat (80) cycle(1'($urandom_range(0, 1)), 1'b0);
        check("presses_ignored", int'(state), 2);

        // Long play saturates the score at 9999.
        repeat (10010 * TICK_DIV) cycle(1'b0, 1'b0);
        check("score_sat", int'(score), 9999);
        repeat (3 * TICK_DIV) cycle(1'b0, 1'b0);
        check("score_hold", int'(score), 9999);

        // Reset asserted in the middle of INVULN.
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        check("pre_rst_inv", int'(state), 3);
        do_reset(1'b0);
        check("mid_rst_state", int'(state), 0);
        check("mid_rst_score", int'(score), 0);

        // A button held through reset release does not count as a press.
        do_reset(1'b1);
        repeat (5) cycle(1'b1, 1'b0);
        check("held_stays_idle", int'(state), 0);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        check("press_after_held", int'(state), 1);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic b;
            logic c;
            b = ($urandom_range(0, 7) == 0) ? ~start_btn : start_btn;
            c = ($urandom_range(0, 24) == 0);
            cycle(b, c);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
